instr_fetch: RTL and testbench

- Fetch stage that sits directly upstream of the synchronous instruction ROM.
- Owns the program counter and drives the ROM address.
- Absorbs the ROM's 1-clock read latency and presents a registered instruction plus its PC to decode with a valid/stall handshake.
- Handles taken branches (flush), halt, and decode back-pressure without losing or duplicating instructions.

---
 rtl/instr_fetch_pkg.sv | 14 +
 rtl/fetch_skid.sv | 47 ++++
 rtl/instr_fetch.sv | 126 ++++++++++++
 tb/tb_instr_fetch.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared defaults and types for the instruction fetch stage.
// Widths here match the default ROM geometry; the fetch modules take them as parameter defaults.
package instr_fetch_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_ADDR_WIDTH = 6;
    localparam int DEFAULT_RESET_PC   = 0;

    typedef struct packed {
        logic [DEFAULT_DATA_WIDTH-1:0] instr;
        logic [DEFAULT_ADDR_WIDTH-1:0] pc;
    } fetch_bundle_t;

endpackage

// File: rtl/fetch_skid.sv
// One-entry holding buffer that catches the ROM word arriving while decode is stalled.
// Flush beats load, load beats drain.
module fetch_skid
    import instr_fetch_pkg::*;
#(
    parameter int WIDTH = DEFAULT_DATA_WIDTH + DEFAULT_ADDR_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             load_i,
    input  logic             drain_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (drain_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage in front of a 1-cycle synchronous instruction ROM: owns the PC,
// absorbs the ROM latency and hands decode a registered instruction with valid/stall.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int RESET_PC   = DEFAULT_RESET_PC
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  stall_i,
    input  logic                  branch_taken_i,
    input  logic [ADDR_WIDTH-1:0] branch_target_i,
    input  logic                  halt_i,
    output logic [ADDR_WIDTH-1:0] rom_addr_o,
    input  logic [DATA_WIDTH-1:0] rom_q_i,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [ADDR_WIDTH-1:0] instr_pc_o,
    output logic                  instr_valid_o
);

    localparam int SKID_WIDTH = DATA_WIDTH + ADDR_WIDTH;

    logic [ADDR_WIDTH-1:0] fetchPc_q, fetchPc_d;
    logic                  reqValid_q, reqValid_d;
    logic [ADDR_WIDTH-1:0] reqPc_q, reqPc_d;
    logic [DATA_WIDTH-1:0] instr_q, instr_d;
    logic [ADDR_WIDTH-1:0] instrPc_q, instrPc_d;
    logic                  instrValid_q, instrValid_d;

    logic                  loadIr;
    logic                  issue;
    logic                  skidValid;
    logic                  skidLoad;
    logic                  skidDrain;
    logic                  skidFlush;
    logic [SKID_WIDTH-1:0] skidData;
    logic [DATA_WIDTH-1:0] skidInstr;
    logic [ADDR_WIDTH-1:0] skidPc;

    assign loadIr = ~instrValid_q | ~stall_i;
    // Blocking issue while the skid is full keeps at most one word in flight.
    assign issue  = ~halt_i & ~skidValid & ~(instrValid_q & stall_i);

    assign {skidInstr, skidPc} = skidData;

    fetch_skid #(
        .WIDTH(SKID_WIDTH)
    ) u_skid (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .flush_i(skidFlush),
        .load_i (skidLoad),
        .drain_i(skidDrain),
        .data_i ({rom_q_i, reqPc_q}),
        .valid_o(skidValid),
        .data_o (skidData)
    );

    always_comb begin
        fetchPc_d    = fetchPc_q;
        reqValid_d   = 1'b0;
        reqPc_d      = reqPc_q;
        instr_d      = instr_q;
        instrPc_d    = instrPc_q;
        instrValid_d = instrValid_q;
        skidLoad     = 1'b0;
        skidDrain    = 1'b0;
        skidFlush    = 1'b0;

        if (branch_taken_i) begin
            fetchPc_d    = branch_target_i;
            skidFlush    = 1'b1;
            instrValid_d = 1'b0;
        end else begin
            reqValid_d = issue;
            if (issue) begin
                reqPc_d   = fetchPc_q;
                fetchPc_d = fetchPc_q + ADDR_WIDTH'(1);
            end

            // The skid always holds the oldest word, so it drains before any ROM data.
            if (skidValid) begin
                if (loadIr) begin
                    instr_d      = skidInstr;
                    instrPc_d    = skidPc;
                    instrValid_d = 1'b1;
                    skidDrain    = 1'b1;
                end
            end else if (reqValid_q && loadIr) begin
                instr_d      = rom_q_i;
                instrPc_d    = reqPc_q;
                instrValid_d = 1'b1;
            end else if (reqValid_q) begin
                skidLoad = 1'b1;
            end else if (loadIr) begin
                instrValid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fetchPc_q    <= ADDR_WIDTH'(RESET_PC);
            reqValid_q   <= 1'b0;
            reqPc_q      <= '0;
            instr_q      <= '0;
            instrPc_q    <= '0;
            instrValid_q <= 1'b0;
        end else begin
            fetchPc_q    <= fetchPc_d;
            reqValid_q   <= reqValid_d;
            reqPc_q      <= reqPc_d;
            instr_q      <= instr_d;
            instrPc_q    <= instrPc_d;
            instrValid_q <= instrValid_d;
        end
    end

    assign rom_addr_o    = fetchPc_q;
    assign instr_o       = instr_q;
    assign instr_pc_o    = instrPc_q;
    assign instr_valid_o = instrValid_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch against a behavioural 1-cycle ROM holding word[n] = n + 100.
module tb_instr_fetch;
    import instr_fetch_pkg::*;

    localparam int DW = DEFAULT_DATA_WIDTH;
    localparam int AW = DEFAULT_ADDR_WIDTH;

    logic          clk;
    logic          rstN;
    logic          stall;
    logic          branchTaken;
    logic [AW-1:0] branchTarget;
    logic          halt;
    logic [AW-1:0] romAddr;
    logic [DW-1:0] romQ;
    logic [DW-1:0] instr;
    logic [AW-1:0] instrPc;
    logic          instrValid;

    int assertCount = 0;
    int failCount   = 0;
    bit benchDone   = 0;

    instr_fetch #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .RESET_PC  (0)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rstN),
        .stall_i        (stall),
        .branch_taken_i (branchTaken),
        .branch_target_i(branchTarget),
        .halt_i         (halt),
        .rom_addr_o     (romAddr),
        .rom_q_i        (romQ),
        .instr_o        (instr),
        .instr_pc_o     (instrPc),
        .instr_valid_o  (instrValid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) romQ <= DW'(romAddr) + DW'(100);

    // A full skid must never coexist with an outstanding ROM request.
    always @(negedge clk) begin
        if (rstN && !benchDone) begin
            assertCount++;
            assert (!(dut.skidValid && dut.reqValid_q)) else begin
                failCount++;
                $error("[TB] FAIL invariant: skid_valid=%0b req_valid=%0b expected not both 1",
                       dut.skidValid, dut.reqValid_q);
            end
        end
    end

    task automatic applyStimulus(input logic s, input logic b, input logic [AW-1:0] t, input logic h);
        stall        = s;
        branchTaken  = b;
        branchTarget = t;
        halt         = h;
    endtask

    task automatic nextEdge();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic expValid, input fetch_bundle_t exp);
        assertCount++;
        assert (instrValid === expValid) else begin
            failCount++;
            $error("[TB] FAIL %s valid: observed %0b expected %0b", tag, instrValid, expValid);
        end
        if (expValid) begin
            assertCount++;
            assert (instr === exp.instr && instrPc === exp.pc) else begin
                failCount++;
                $error("[TB] FAIL %s word: observed %0d/%0d expected %0d/%0d",
                       tag, instr, instrPc, exp.instr, exp.pc);
            end
        end
    endtask

    task automatic checkAddr(input string tag, input logic [AW-1:0] expAddr);
        assertCount++;
        assert (romAddr === expAddr) else begin
            failCount++;
            $error("[TB] FAIL %s rom_addr: observed %0d expected %0d", tag, romAddr, expAddr);
        end
    endtask

    function automatic fetch_bundle_t word(input int pc);
        fetch_bundle_t w;
        w.instr = DW'(pc + 100);
        w.pc    = AW'(pc);
        return w;
    endfunction

    initial begin
        rstN = 1'b0;
        applyStimulus(1'b0, 1'b0, '0, 1'b0);
        #2;
        checkOutput("reset", 1'b0, word(0));
        checkAddr("reset", 6'd0);
        assertCount++;
        assert (instr === '0 && instrPc === '0) else begin
            failCount++;
            $error("[TB] FAIL reset regs: observed %0d/%0d expected 0/0", instr, instrPc);
        end
        #10 rstN = 1'b1;

        // Streaming from reset: issue edge, then load edge.
        nextEdge(); checkOutput("startup e1", 1'b0, word(0));
        nextEdge(); checkOutput("startup e2", 1'b1, word(0));
        nextEdge(); checkOutput("stream 1", 1'b1, word(1));
        nextEdge(); checkOutput("stream 2", 1'b1, word(2));
        nextEdge(); checkOutput("stream 3", 1'b1, word(3));
        nextEdge(); checkOutput("stream 4", 1'b1, word(4));

        // Three stalled edges at pc 4: 105 lands in the skid, rom_addr freezes at 6.
        applyStimulus(1'b1, 1'b0, '0, 1'b0);
        nextEdge(); checkOutput("stall 1", 1'b1, word(4)); checkAddr("stall 1", 6'd6);
        nextEdge(); checkOutput("stall 2", 1'b1, word(4)); checkAddr("stall 2", 6'd6);
        nextEdge(); checkOutput("stall 3", 1'b1, word(4)); checkAddr("stall 3", 6'd6);
        applyStimulus(1'b0, 1'b0, '0, 1'b0);
        nextEdge(); checkOutput("skid drain", 1'b1, word(5));
        nextEdge(); checkOutput("bubble", 1'b0, word(5)); checkAddr("bubble", 6'd7);
        nextEdge(); checkOutput("resume", 1'b1, word(6));

        // Fill the skid with 107, then branch to 20 while still stalled.
        applyStimulus(1'b1, 1'b0, '0, 1'b0);
        nextEdge(); checkOutput("pre-branch", 1'b1, word(6));
        applyStimulus(1'b1, 1'b1, 6'd20, 1'b0);
        nextEdge(); checkOutput("branch e1", 1'b0, word(0)); checkAddr("branch e1", 6'd20);
        applyStimulus(1'b0, 1'b0, '0, 1'b0);
        nextEdge(); checkOutput("branch e2", 1'b0, word(0));
        nextEdge(); checkOutput("branch target", 1'b1, word(20));
        nextEdge(); checkOutput("branch next", 1'b1, word(21));

        // Branch near the top of the address space to exercise wrap.
        applyStimulus(1'b0, 1'b1, 6'd62, 1'b0);
        nextEdge(); checkOutput("wrap br", 1'b0, word(0));
        applyStimulus(1'b0, 1'b0, '0, 1'b0);
        nextEdge(); checkOutput("wrap e2", 1'b0, word(0));
        nextEdge(); checkOutput("wrap 62", 1'b1, word(62)); checkAddr("wrap 62", 6'd0);
        nextEdge(); checkOutput("wrap 63", 1'b1, word(63));
        nextEdge(); checkOutput("wrap 0", 1'b1, word(0));
        nextEdge(); checkOutput("wrap 1", 1'b1, word(1));
        for (int p = 2; p <= 7; p++) begin
            nextEdge(); checkOutput("run to 7", 1'b1, word(p));
        end

        // Halt at pc 7: only the in-flight 108 comes out.
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        nextEdge(); checkOutput("halt drain", 1'b1, word(8));
        nextEdge(); checkOutput("halt idle 1", 1'b0, word(0)); checkAddr("halt idle 1", 6'd9);
        nextEdge(); checkOutput("halt idle 2", 1'b0, word(0)); checkAddr("halt idle 2", 6'd9);
        applyStimulus(1'b0, 1'b0, '0, 1'b0);
        nextEdge(); checkOutput("unhalt e1", 1'b0, word(0));
        nextEdge(); checkOutput("unhalt e2", 1'b1, word(9));

        // Asynchronous reset between edges.
        #2 rstN = 1'b0;
        #1;
        checkOutput("async rst", 1'b0, word(0));
        checkAddr("async rst", 6'd0);
        assertCount++;
        assert (instr === '0 && instrPc === '0) else begin
            failCount++;
            $error("[TB] FAIL async rst regs: observed %0d/%0d expected 0/0", instr, instrPc);
        end
        @(posedge clk);
        #3 rstN = 1'b1;
        nextEdge(); checkOutput("restart e1", 1'b0, word(0));
        nextEdge(); checkOutput("restart e2", 1'b1, word(0));
        nextEdge(); checkOutput("restart e3", 1'b1, word(1));

        benchDone = 1'b1;
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
